// File: rtl/regfile_port_arbiter_pkg.sv
// Shared types for the register-file port arbiter.
// Slot grants, FSM states and default widths.
package regctl_pkg;

  localparam int DATA_W = 72;
  localparam int ADDR_W = 6;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_READ,
    GNT_WRITE
  } grant_t;

  typedef enum logic {
    ST_RUN,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/regfile_port_arbiter_if.sv
// Client/register-file bundle of the port arbiter.
// slave = arbiter side, master = issue/ALU/regfile side.
interface regfile_port_arbiter_if #(
  parameter int DATA_W = regctl_pkg::DATA_W,
  parameter int ADDR_W = regctl_pkg::ADDR_W
);

  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic              rd_rsp_valid;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;

  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  logic              drain;
  logic              drain_done;

  logic              rf_write;
  logic [ADDR_W-1:0] rf_reg1_address;
  logic [ADDR_W-1:0] rf_reg2_address;
  logic [ADDR_W-1:0] rf_reg_r_address;
  logic [DATA_W-1:0] rf_result_in;
  logic [DATA_W-1:0] rf_data_out1;
  logic [DATA_W-1:0] rf_data_out2;

  modport slave (
    input  rd_req_valid, rd_addr1, rd_addr2,
    input  wb_valid, wb_addr, wb_data,
    input  drain, rf_data_out1, rf_data_out2,
    output rd_req_ready, rd_rsp_valid,
    output rd_data1, rd_data2,
    output wb_ready, drain_done,
    output rf_write, rf_reg1_address,
    output rf_reg2_address, rf_reg_r_address,
    output rf_result_in
  );

  modport master (
    output rd_req_valid, rd_addr1, rd_addr2,
    output wb_valid, wb_addr, wb_data,
    output drain, rf_data_out1, rf_data_out2,
    input  rd_req_ready, rd_rsp_valid,
    input  rd_data1, rd_data2,
    input  wb_ready, drain_done,
    input  rf_write, rf_reg1_address,
    input  rf_reg2_address, rf_reg_r_address,
    input  rf_result_in
  );

endinterface

// File: rtl/regfile_port_arbiter_wb_fifo.sv
// Writeback buffer: small FIFO of {addr, data}.
// Entry views are presented oldest-first; index 0 is the head.
module regctl_wb_fifo #(
  parameter int DATA_W = 72,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 2,
  parameter int CW     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [CW-1:0]     count,
  output logic              ent_valid [DEPTH],
  output logic [ADDR_W-1:0] ent_addr  [DEPTH],
  output logic [DATA_W-1:0] ent_data  [DEPTH]
);

  localparam int PW = $clog2(DEPTH);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= push_addr;
      data_q[wr_ptr] <= push_data;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_view
    logic [PW-1:0] idx;
    assign idx          = rd_ptr + PW'(k);
    assign ent_valid[k] = CW'(k) < count;
    assign ent_addr[k]  = addr_q[idx];
    assign ent_data[k]  = data_q[idx];
  end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Single-port register-file sequencer: operand reads vs queued writebacks.
// Define REGCTL_BYPASS_EN to forward buffered writebacks to reads.
module regfile_port_arbiter #(
  parameter int DATA_W     = regctl_pkg::DATA_W,
  parameter int ADDR_W     = regctl_pkg::ADDR_W,
  parameter int WB_DEPTH   = 2,
  parameter int STARVE_MAX = 4
) (
  input logic             clk,
  input logic             reset,
  regfile_port_arbiter_if.slave bus
);

  import regctl_pkg::*;

  localparam int CW = $clog2(WB_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  grant_t            grant;
  state_t            state;
  logic [SW-1:0]     starve_cnt;
  logic [CW-1:0]     count;
  logic              ent_valid [WB_DEPTH];
  logic [ADDR_W-1:0] ent_addr  [WB_DEPTH];
  logic [DATA_W-1:0] ent_data  [WB_DEPTH];

  logic              push;
  logic              pop;
  logic              nonempty;
  logic              force_wr;
  logic              hit1;
  logic              hit2;
  logic              stall;
  logic              rsp_q;

  logic [ADDR_W-1:0] reg1_q;
  logic [ADDR_W-1:0] reg2_q;
  logic [ADDR_W-1:0] regr_q;
  logic [DATA_W-1:0] res_q;

  assign push = bus.wb_valid && bus.wb_ready;
  assign pop  = grant == GNT_WRITE;

  regctl_wb_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (WB_DEPTH),
    .CW     (CW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_addr (bus.wb_addr),
    .push_data (bus.wb_data),
    .pop       (pop),
    .count     (count),
    .ent_valid (ent_valid),
    .ent_addr  (ent_addr),
    .ent_data  (ent_data)
  );

  // Only registered entries count; a same-cycle push orders after the read.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int k = 0; k < WB_DEPTH; k++) begin
      if (ent_valid[k] && ent_addr[k] == bus.rd_addr1) hit1 = 1'b1;
      if (ent_valid[k] && ent_addr[k] == bus.rd_addr2) hit2 = 1'b1;
    end
  end

`ifdef REGCTL_BYPASS_EN
  logic [DATA_W-1:0] byp1_d;
  logic [DATA_W-1:0] byp2_d;
  logic [DATA_W-1:0] byp1_q;
  logic [DATA_W-1:0] byp2_q;
  logic              byp1_hit_q;
  logic              byp2_hit_q;

  // Later (younger) entries overwrite earlier matches.
  always_comb begin
    byp1_d = '0;
    byp2_d = '0;
    for (int k = 0; k < WB_DEPTH; k++) begin
      if (ent_valid[k] && ent_addr[k] == bus.rd_addr1) byp1_d = ent_data[k];
      if (ent_valid[k] && ent_addr[k] == bus.rd_addr2) byp2_d = ent_data[k];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      byp1_hit_q <= 1'b0;
      byp2_hit_q <= 1'b0;
      byp1_q     <= '0;
      byp2_q     <= '0;
    end else if (grant == GNT_READ) begin
      byp1_hit_q <= hit1;
      byp2_hit_q <= hit2;
      byp1_q     <= byp1_d;
      byp2_q     <= byp2_d;
    end
  end

  assign stall = 1'b0;
  assign bus.rd_data1 = !bus.rd_rsp_valid ? '0 :
                        byp1_hit_q ? byp1_q : bus.rf_data_out1;
  assign bus.rd_data2 = !bus.rd_rsp_valid ? '0 :
                        byp2_hit_q ? byp2_q : bus.rf_data_out2;
`else
  assign stall = bus.rd_req_valid && (hit1 || hit2);
  assign bus.rd_data1 = bus.rd_rsp_valid ? bus.rf_data_out1 : '0;
  assign bus.rd_data2 = bus.rd_rsp_valid ? bus.rf_data_out2 : '0;
`endif

  assign nonempty = count != '0;
  assign force_wr = nonempty &&
                    (count == CW'(WB_DEPTH) ||
                     state == ST_DRAIN ||
                     starve_cnt == SW'(STARVE_MAX) ||
                     stall);

  always_comb begin
    grant = GNT_NONE;
    if (reset)
      grant = GNT_NONE;
    else if (force_wr)
      grant = GNT_WRITE;
    else if (bus.rd_req_valid && state == ST_RUN)
      grant = GNT_READ;
    else if (nonempty)
      grant = GNT_WRITE;
  end

  assign bus.rd_req_ready = grant == GNT_READ;
  assign bus.wb_ready     = !reset && count < CW'(WB_DEPTH);
  assign bus.rd_rsp_valid = rsp_q && !reset;
  assign bus.drain_done   = !reset && state == ST_DRAIN && !nonempty;

  // Idle slots keep the register-file address/data lines steady.
  always_comb begin
    bus.rf_write         = 1'b0;
    bus.rf_reg1_address  = reg1_q;
    bus.rf_reg2_address  = reg2_q;
    bus.rf_reg_r_address = regr_q;
    bus.rf_result_in     = res_q;
    unique case (grant)
      GNT_READ: begin
        bus.rf_reg1_address = bus.rd_addr1;
        bus.rf_reg2_address = bus.rd_addr2;
      end
      GNT_WRITE: begin
        bus.rf_write         = 1'b1;
        bus.rf_reg_r_address = ent_addr[0];
        bus.rf_result_in     = ent_data[0];
      end
      default: ;
    endcase
    if (reset) begin
      bus.rf_reg1_address  = '0;
      bus.rf_reg2_address  = '0;
      bus.rf_reg_r_address = '0;
      bus.rf_result_in     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg1_q <= '0;
      reg2_q <= '0;
      regr_q <= '0;
      res_q  <= '0;
      rsp_q  <= 1'b0;
    end else begin
      reg1_q <= bus.rf_reg1_address;
      reg2_q <= bus.rf_reg2_address;
      regr_q <= bus.rf_reg_r_address;
      res_q  <= bus.rf_result_in;
      rsp_q  <= grant == GNT_READ;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      starve_cnt <= '0;
    else if (grant == GNT_WRITE || !nonempty)
      starve_cnt <= '0;
    else if (grant == GNT_READ && starve_cnt != SW'(STARVE_MAX))
      starve_cnt <= starve_cnt + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= ST_RUN;
    else begin
      unique case (state)
        ST_RUN:   if (bus.drain)  state <= ST_DRAIN;
        ST_DRAIN: if (!bus.drain) state <= ST_RUN;
        default:  state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter with a scoreboard on
// read responses and register-file writes.
module tb_regfile_port_arbiter;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  regfile_port_arbiter_if bus ();

  regfile_port_arbiter #(
    .DATA_W     (72),
    .ADDR_W     (6),
    .WB_DEPTH   (2),
    .STARVE_MAX (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Register-file model: registered read, single write port.
  logic [71:0] regs [64];
  logic        rf_init_done = 1'b0;

  always @(posedge clk) begin
    if (!rf_init_done) begin
      for (int i = 0; i < 64; i++) regs[i] <= 72'h100 + 72'(i);
      regs[2] <= 72'h11;
      rf_init_done <= 1'b1;
    end else if (bus.rf_write) begin
      regs[bus.rf_reg_r_address] <= bus.rf_result_in;
    end
    bus.rf_data_out1 <= regs[bus.rf_reg1_address];
    bus.rf_data_out2 <= regs[bus.rf_reg2_address];
  end

  int checks = 0;
  int errors = 0;
  logic [143:0] exp_rd [$];
  logic [77:0]  exp_wr [$];
  logic [143:0] e_rd;
  logic [77:0]  e_wr;

  task automatic chk(input string name, input logic [143:0] got,
                     input logic [143:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.rd_rsp_valid) begin
        checks++;
        if (exp_rd.size() == 0) begin
          errors++;
          $display("FAIL rd_rsp_unexpected: got %0h want none",
                   {bus.rd_data1, bus.rd_data2});
        end else begin
          checks--;
          e_rd = exp_rd.pop_front();
          chk("rd_data", {bus.rd_data1, bus.rd_data2}, e_rd);
        end
      end
      if (bus.rf_write) begin
        checks++;
        if (exp_wr.size() == 0) begin
          errors++;
          $display("FAIL rf_write_unexpected: got %0h want none",
                   {bus.rf_reg_r_address, bus.rf_result_in});
        end else begin
          checks--;
          e_wr = exp_wr.pop_front();
          chk("rf_write", {bus.rf_reg_r_address, bus.rf_result_in}, e_wr);
        end
      end
    end
  end

  task automatic rd(input logic v, input logic [5:0] a1, input logic [5:0] a2);
    bus.rd_req_valid = v;
    bus.rd_addr1     = a1;
    bus.rd_addr2     = a2;
  endtask

  task automatic wb(input logic v, input logic [5:0] a, input logic [71:0] d);
    bus.wb_valid = v;
    bus.wb_addr  = a;
    bus.wb_data  = d;
  endtask

  task automatic exp_read(input logic [71:0] d1, input logic [71:0] d2);
    exp_rd.push_back({d1, d2});
  endtask

  task automatic exp_write(input logic [5:0] a, input logic [71:0] d);
    exp_wr.push_back({a, d});
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.drain = 1'b0;
    rd(1'b1, 6'd1, 6'd2);
    wb(1'b1, 6'd5, 72'h1);
    nxt();
    mid();
    chk("rst_wb_ready", bus.wb_ready, 0);
    chk("rst_rd_ready", bus.rd_req_ready, 0);
    chk("rst_rf_write", bus.rf_write, 0);
    chk("rst_rsp_valid", bus.rd_rsp_valid, 0);
    chk("rst_drain_done", bus.drain_done, 0);
    chk("rst_reg1", bus.rf_reg1_address, 0);
    chk("rst_result", bus.rf_result_in, 0);
    chk("rst_rd_data1", bus.rd_data1, 0);
    nxt();
    reset = 1'b0;
    rd(1'b0, 6'd0, 6'd0);
    wb(1'b0, 6'd0, 72'h0);
    mid();
    chk("post_rst_wb_ready", bus.wb_ready, 1);
    chk("post_rst_rf_write", bus.rf_write, 0);
    nxt();

    // Lone writeback lands one cycle later.
    wb(1'b1, 6'd5, 72'h1);
    exp_write(6'd5, 72'h1);
    mid();
    chk("t1_wb_ready", bus.wb_ready, 1);
    chk("t1_no_write_yet", bus.rf_write, 0);
    nxt();
    wb(1'b0, 6'd0, 72'h0);
    mid();
    chk("t1_write", bus.rf_write, 1);
    chk("t1_addr", bus.rf_reg_r_address, 5);
    nxt();
    mid();
    chk("t1_empty_after", bus.rf_write, 0);
    nxt();

    // Starvation limit.
    wb(1'b1, 6'd9, 72'h99);
    exp_write(6'd9, 72'h99);
    rd(1'b1, 6'd1, 6'd2);
    exp_read(72'h101, 72'h11);
    mid();
    chk("t2_first_read", bus.rd_req_ready, 1);
    nxt();
    wb(1'b0, 6'd0, 72'h0);
    for (int i = 0; i < 4; i++) begin
      exp_read(72'h101, 72'h11);
      mid();
      chk("t2_read_grant", bus.rd_req_ready, 1);
      nxt();
    end
    mid();
    chk("t2_starved_ready", bus.rd_req_ready, 0);
    chk("t2_starved_write", bus.rf_write, 1);
    nxt();
    exp_read(72'h101, 72'h11);
    mid();
    chk("t2_resume", bus.rd_req_ready, 1);
    nxt();
    rd(1'b0, 6'd0, 6'd0);
    mid();
    nxt();

    // Buffer full.
    wb(1'b1, 6'd3, 72'h33);
    exp_write(6'd3, 72'h33);
    rd(1'b1, 6'd1, 6'd2);
    exp_read(72'h101, 72'h11);
    mid();
    chk("t3_read0", bus.rd_req_ready, 1);
    nxt();
    wb(1'b1, 6'd4, 72'h44);
    exp_write(6'd4, 72'h44);
    exp_read(72'h101, 72'h11);
    mid();
    chk("t3_wb_ready1", bus.wb_ready, 1);
    chk("t3_read1", bus.rd_req_ready, 1);
    nxt();
    wb(1'b0, 6'd0, 72'h0);
    mid();
    chk("t3_full_wb_ready", bus.wb_ready, 0);
    chk("t3_full_rd_ready", bus.rd_req_ready, 0);
    chk("t3_full_write", bus.rf_write, 1);
    nxt();
    exp_read(72'h101, 72'h11);
    mid();
    chk("t3_wb_ready_back", bus.wb_ready, 1);
    chk("t3_read_back", bus.rd_req_ready, 1);
    nxt();
    rd(1'b0, 6'd0, 6'd0);
    mid();
    chk("t3_second_write", bus.rf_write, 1);
    nxt();
    mid();
    chk("t3_idle", bus.rf_write, 0);
    nxt();

    // Read-after-write hazard on reg 7.
    wb(1'b1, 6'd7, 72'hABC);
    exp_write(6'd7, 72'hABC);
    mid();
    nxt();
    wb(1'b0, 6'd0, 72'h0);
    rd(1'b1, 6'd7, 6'd1);
`ifdef REGCTL_BYPASS_EN
    exp_read(72'hABC, 72'h101);
    mid();
    chk("t4_byp_ready", bus.rd_req_ready, 1);
    chk("t4_byp_no_write", bus.rf_write, 0);
    nxt();
    rd(1'b0, 6'd0, 6'd0);
    mid();
    chk("t4_byp_write", bus.rf_write, 1);
    nxt();
`else
    mid();
    chk("t4_stall_ready", bus.rd_req_ready, 0);
    chk("t4_stall_write", bus.rf_write, 1);
    nxt();
    exp_read(72'hABC, 72'h101);
    mid();
    chk("t4_after_stall", bus.rd_req_ready, 1);
    nxt();
    rd(1'b0, 6'd0, 6'd0);
`endif
    mid();
    nxt();

    // Same-cycle read and writeback: read sees the old value.
    wb(1'b1, 6'd2, 72'h55);
    exp_write(6'd2, 72'h55);
    rd(1'b1, 6'd2, 6'd2);
    exp_read(72'h11, 72'h11);
    mid();
    chk("t5_read_ready", bus.rd_req_ready, 1);
    nxt();
    wb(1'b0, 6'd0, 72'h0);
    rd(1'b0, 6'd0, 6'd0);
    mid();
    chk("t5_write", bus.rf_write, 1);
    nxt();
    rd(1'b1, 6'd2, 6'd2);
    exp_read(72'h55, 72'h55);
    mid();
    chk("t5_reread", bus.rd_req_ready, 1);
    nxt();
    rd(1'b0, 6'd0, 6'd0);
    mid();
    nxt();

    // Drain with two queued entries.
    wb(1'b1, 6'd12, 72'hC);
    exp_write(6'd12, 72'hC);
    rd(1'b1, 6'd1, 6'd2);
    exp_read(72'h101, 72'h55);
    mid();
    nxt();
    wb(1'b1, 6'd13, 72'hD);
    exp_write(6'd13, 72'hD);
    exp_read(72'h101, 72'h55);
    mid();
    nxt();
    wb(1'b0, 6'd0, 72'h0);
    bus.drain = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mid();
      chk("t6_drain_rd_ready", bus.rd_req_ready, 0);
      chk("t6_drain_write", bus.rf_write, 1);
      chk("t6_drain_not_done", bus.drain_done, 0);
      nxt();
    end
    mid();
    chk("t6_drain_done", bus.drain_done, 1);
    chk("t6_drained_idle", bus.rf_write, 0);
    chk("t6_done_rd_ready", bus.rd_req_ready, 0);
    nxt();
    bus.drain = 1'b0;
    mid();
    chk("t6_exit_rd_ready", bus.rd_req_ready, 0);
    nxt();
    exp_read(72'h101, 72'h55);
    mid();
    chk("t6_run_rd_ready", bus.rd_req_ready, 1);
    chk("t6_run_done_low", bus.drain_done, 0);
    nxt();
    rd(1'b0, 6'd0, 6'd0);
    mid();
    nxt();

    // Reset with a full buffer and a response in flight.
    wb(1'b1, 6'd10, 72'hA);
    rd(1'b1, 6'd1, 6'd2);
    exp_read(72'h101, 72'h55);
    mid();
    nxt();
    wb(1'b1, 6'd11, 72'hB);
    mid();
    chk("t7_second_read", bus.rd_req_ready, 1);
    nxt();
    wb(1'b0, 6'd0, 72'h0);
    rd(1'b0, 6'd0, 6'd0);
    reset = 1'b1;
    mid();
    chk("t7_rst_rsp", bus.rd_rsp_valid, 0);
    chk("t7_rst_write", bus.rf_write, 0);
    nxt();
    reset = 1'b0;
    mid();
    chk("t7_after_rsp", bus.rd_rsp_valid, 0);
    chk("t7_after_write", bus.rf_write, 0);
    chk("t7_after_wb_ready", bus.wb_ready, 1);
    nxt();
    rd(1'b1, 6'd10, 6'd11);
    exp_read(72'h10A, 72'h10B);
    mid();
    chk("t7_empty_no_write", bus.rf_write, 0);
    nxt();
    rd(1'b0, 6'd0, 6'd0);
    mid();
    nxt();
    mid();
    nxt();

    chk("rd_queue_empty", 144'(exp_rd.size()), 0);
    chk("wr_queue_empty", 144'(exp_wr.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
